// File: rtl/wavelet_pkg.sv
// Shared defaults, FSM encoding and lane helpers for the time-multiplexed wavelet FIR.
// Imported by the MAC unit and by the filter top level.
package wavelet_pkg;

    localparam int DEF_TOTAL_TAPS   = 9;
    localparam int DEF_BITS_PER_TAP = 8;
    localparam int DEF_COEFF_BITS   = 8;
    localparam int DEF_OUT_BITS     = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // LSB position of lane `lane` in a packed vector of `width`-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Counter width able to address `n` lanes; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wavelet_mac_unit.sv
// Registered signed multiply-add: acc_out <= acc_in + a*b when enabled, 0 when cleared.
// The product is formed at full width and sign-extended into the accumulator.
module wavelet_mac_unit #(
    parameter int A_BITS   = 8,
    parameter int B_BITS   = 8,
    parameter int ACC_BITS = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [ACC_BITS-1:0] acc_in_i,
    input  logic signed [A_BITS-1:0]   a_i,
    input  logic signed [B_BITS-1:0]   b_i,
    input  logic                       clr_i,
    input  logic                       en_i,
    output logic signed [ACC_BITS-1:0] acc_out_o
);

    localparam int PROD_BITS = A_BITS + B_BITS;

    logic signed [PROD_BITS-1:0] prod;
    logic signed [ACC_BITS-1:0]  acc_d;
    logic signed [ACC_BITS-1:0]  acc_q;

    always_comb begin
        prod  = PROD_BITS'(a_i) * PROD_BITS'(b_i);
        acc_d = acc_in_i + ACC_BITS'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_out_o = acc_q;

endmodule

// File: rtl/wavelet_mac_filter.sv
// Snapshots a packed tap/coefficient pair and computes their signed dot product,
// one multiply-accumulate per cycle, then strobes the result for one cycle.
module wavelet_mac_filter
    import wavelet_pkg::*;
#(
    parameter int TOTAL_TAPS   = DEF_TOTAL_TAPS,
    parameter int BITS_PER_TAP = DEF_BITS_PER_TAP,
    parameter int TOTAL_BITS   = TOTAL_TAPS * BITS_PER_TAP,
    parameter int COEFF_BITS   = DEF_COEFF_BITS,
    parameter int OUT_BITS     = DEF_OUT_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TOTAL_BITS-1:0]            i_taps,
    input  logic [TOTAL_TAPS*COEFF_BITS-1:0] i_coeffs,
    input  logic                             i_start,
    output logic                             o_busy,
    output logic                             o_valid,
    output logic [OUT_BITS-1:0]              o_result
);

    localparam int IDX_W = idx_width(TOTAL_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_TAPS - 1);

    if (OUT_BITS < BITS_PER_TAP + COEFF_BITS + $clog2(TOTAL_TAPS)) begin : g_width_guard
        $error("wavelet_mac_filter: OUT_BITS too narrow to hold the full dot product");
    end

    state_e                         state_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           busy_q;
    logic                           valid_q;
    logic [OUT_BITS-1:0]            result_q;

    logic signed [BITS_PER_TAP-1:0] tap_q   [TOTAL_TAPS];
    logic signed [COEFF_BITS-1:0]   coeff_q [TOTAL_TAPS];

    logic signed [BITS_PER_TAP-1:0] tap_sel;
    logic signed [COEFF_BITS-1:0]   coeff_sel;
    logic signed [OUT_BITS-1:0]     acc;
    logic                           accept;

    assign accept = (state_q == ST_IDLE) && i_start;

    // NOTE: snapshot registers carry no reset; they are always loaded on acceptance before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < TOTAL_TAPS; k++) begin
                tap_q[k]   <= i_taps[lane_lsb(k, BITS_PER_TAP) +: BITS_PER_TAP];
                coeff_q[k] <= i_coeffs[lane_lsb(k, COEFF_BITS) +: COEFF_BITS];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        tap_sel   = '0;
        coeff_sel = '0;
        for (int k = 0; k < TOTAL_TAPS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                tap_sel   = tap_q[k];
                coeff_sel = coeff_q[k];
            end
        end
    end

    wavelet_mac_unit #(
        .A_BITS   (BITS_PER_TAP),
        .B_BITS   (COEFF_BITS),
        .ACC_BITS (OUT_BITS)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_in_i  (acc),
        .a_i       (tap_sel),
        .b_i       (coeff_sel),
        .clr_i     (accept),
        .en_i      (state_q == ST_ACCUM),
        .acc_out_o (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_ACCUM;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    result_q <= acc;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule
